// File: rtl/trace_event_counter_bank_pkg.sv
// Shared types for the trace-event performance counter bank: event vector,
// per-counter configuration layout and register word encodings.
package trace_event_counter_bank_pkg;

  typedef logic [33:0] cva5_trace_events_t;

  localparam int NUM_TRACE_EVENTS = $bits(cva5_trace_events_t);
  localparam logic [5:0] EVENT_SEL_CYCLES = 6'h3F;

  localparam logic [1:0] WORD_CFG = 2'd0;
  localparam logic [1:0] WORD_LO  = 2'd1;
  localparam logic [1:0] WORD_HI  = 2'd2;

  typedef struct packed {
    logic       ovf_flag;
    logic       ovf_ie;
    logic       edge_mode;
    logic       enable;
    logic [5:0] sel;
  } event_counter_cfg_t;

  // Register view of cfg: flag lives in bit 31, control fields in [8:0].
  function automatic logic [31:0] cfg_word(input event_counter_cfg_t c);
    return {c.ovf_flag, 22'b0, c.ovf_ie, c.edge_mode, c.enable, c.sel};
  endfunction

endpackage

// File: rtl/trace_event_counter_bank_counter.sv
// One counter slice: configuration, count register, event qualification,
// overflow tracking and write/clear/increment precedence.
module trace_event_counter
  import trace_event_counter_bank_pkg::*;
#(
  parameter int COUNTER_W = 48
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_TRACE_EVENTS-1:0] ev_q,
  input  logic [NUM_TRACE_EVENTS-1:0] ev_qq,
  input  logic                        freeze,
  input  logic                        clear_all,
  input  logic                        cfg_we,
  input  logic                        lo_we,
  input  logic                        hi_we,
  input  logic [31:0]                 wdata,
  output event_counter_cfg_t          cfg,
  output logic [COUNTER_W-1:0]        count
);

  logic [63:0] q_ext, qq_ext;
  logic        ev_hit, inc, wrap;

  // Widen to 64 so any 6-bit selector indexes in range; unused selects are masked below.
  assign q_ext  = 64'(ev_q);
  assign qq_ext = 64'(ev_qq);

  always_comb begin
    ev_hit = 1'b0;
    if (cfg.sel == EVENT_SEL_CYCLES)
      ev_hit = 1'b1;
    else if (cfg.sel < 6'(NUM_TRACE_EVENTS))
      ev_hit = cfg.edge_mode ? (q_ext[cfg.sel] & ~qq_ext[cfg.sel]) : q_ext[cfg.sel];
  end

  // A write to either count word owns the register for that cycle.
  assign inc  = ev_hit & cfg.enable & ~freeze & ~lo_we & ~hi_we;
  assign wrap = inc & (&count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg   <= '0;
      count <= '0;
    end else begin
      if (cfg_we) begin
        cfg.sel       <= wdata[5:0];
        cfg.enable    <= wdata[6];
        cfg.edge_mode <= wdata[7];
        cfg.ovf_ie    <= wdata[8];
      end
      if (clear_all) begin
        count        <= '0;
        cfg.ovf_flag <= 1'b0;
      end else begin
        if (lo_we) count[31:0]          <= wdata;
        if (hi_we) count[COUNTER_W-1:32] <= wdata[COUNTER_W-33:0];
        if (inc)   count                 <= count + COUNTER_W'(1);
        // A same-cycle overflow beats the write-1-to-clear.
        if (wrap)
          cfg.ovf_flag <= 1'b1;
        else if (cfg_we && wdata[31])
          cfg.ovf_flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/trace_event_counter_bank.sv
// Bank of programmable trace-event counters behind a 32-bit word-addressed
// register port, with atomic 64-bit reads and a combined overflow interrupt.
module trace_event_counter_bank
  import trace_event_counter_bank_pkg::*;
#(
  parameter int NUM_COUNTERS = 8,
  parameter int COUNTER_W    = 48,
  parameter int ADDR_W       = $clog2(NUM_COUNTERS + 1) + 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_TRACE_EVENTS-1:0] events,
  input  logic                        reg_valid,
  input  logic                        reg_write,
  input  logic [ADDR_W-1:0]           reg_addr,
  input  logic [31:0]                 reg_wdata,
  output logic [31:0]                 reg_rdata,
  output logic                        reg_rvalid,
  output logic                        overflow_irq
);

  localparam int IDX_W = ADDR_W - 2;

  logic [NUM_TRACE_EVENTS-1:0]              ev_q, ev_qq;
  logic [IDX_W-1:0]                         idx, hi_idx;
  logic [1:0]                               word;
  logic                                     rd_req, wr_req, is_glb, glb_we, clear_all;
  logic                                     freeze, hi_vld, hi_hit;
  logic [31:0]                              hi_latch, hi_sel, rd_mux;
  event_counter_cfg_t [NUM_COUNTERS-1:0]    cfg;
  logic [NUM_COUNTERS-1:0][COUNTER_W-1:0]   count;
  logic [NUM_COUNTERS-1:0][31:0]            hi_live;
  logic [NUM_COUNTERS-1:0]                  irq_vec;

  assign idx       = reg_addr[ADDR_W-1:2];
  assign word      = reg_addr[1:0];
  assign rd_req    = reg_valid & ~reg_write;
  assign wr_req    = reg_valid & reg_write;
  assign is_glb    = (idx == IDX_W'(NUM_COUNTERS));
  assign glb_we    = wr_req & is_glb & (word == WORD_CFG);
  assign clear_all = glb_we & reg_wdata[1];
  assign hi_hit    = hi_vld & (hi_idx == idx);

  for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_cnt
    logic sel_wr;
    assign sel_wr     = wr_req & (idx == IDX_W'(i));
    assign hi_live[i] = 32'(count[i][COUNTER_W-1:32]);
    assign irq_vec[i] = cfg[i].ovf_flag & cfg[i].ovf_ie;

    trace_event_counter #(.COUNTER_W(COUNTER_W)) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .ev_q      (ev_q),
      .ev_qq     (ev_qq),
      .freeze    (freeze),
      .clear_all (clear_all),
      .cfg_we    (sel_wr & (word == WORD_CFG)),
      .lo_we     (sel_wr & (word == WORD_LO)),
      .hi_we     (sel_wr & (word == WORD_HI)),
      .wdata     (reg_wdata),
      .cfg       (cfg[i]),
      .count     (count[i])
    );
  end

  always_comb begin
    rd_mux = '0;
    hi_sel = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (idx == IDX_W'(i)) begin
        hi_sel = hi_live[i];
        case (word)
          WORD_CFG: rd_mux = cfg_word(cfg[i]);
          WORD_LO:  rd_mux = count[i][31:0];
          WORD_HI:  rd_mux = hi_hit ? hi_latch : hi_live[i];
          default:  rd_mux = '0;
        endcase
      end
    end
    if (is_glb && word == WORD_CFG)
      rd_mux = {31'b0, freeze};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_q         <= '0;
      ev_qq        <= '0;
      freeze       <= 1'b0;
      hi_latch     <= '0;
      hi_idx       <= '0;
      hi_vld       <= 1'b0;
      reg_rdata    <= '0;
      reg_rvalid   <= 1'b0;
      overflow_irq <= 1'b0;
    end else begin
      ev_q         <= events;
      ev_qq        <= ev_q;
      reg_rvalid   <= rd_req;
      overflow_irq <= |irq_vec;
      if (rd_req)
        reg_rdata <= rd_mux;
      if (glb_we)
        freeze <= reg_wdata[0];
      // Low-word read snapshots the upper bits; the paired high read consumes it.
      if (rd_req && !is_glb && word == WORD_LO) begin
        hi_latch <= hi_sel;
        hi_idx   <= idx;
        hi_vld   <= 1'b1;
      end else if (rd_req && word == WORD_HI && hi_hit) begin
        hi_vld <= 1'b0;
      end
    end
  end

endmodule
